// File: rtl/efgj03l_video_pkg.sv
// Shared types and constants for the EFGJ03L video pixel path.
package efgj03l_video_pkg;

  typedef logic [3:0] pal_idx_t;

  localparam int unsigned FG_MSB = 7;
  localparam int unsigned FG_LSB = 4;
  localparam int unsigned BG_MSB = 3;
  localparam int unsigned BG_LSB = 0;

  localparam int unsigned DEFAULT_PIX_DIV   = 2;
  localparam int unsigned DEFAULT_BYTE_BITS = 8;

  function automatic pal_idx_t pix_select(input logic [7:0] attr, input logic fg);
    return fg ? attr[FG_MSB:FG_LSB] : attr[BG_MSB:BG_LSB];
  endfunction

endpackage

// File: rtl/video_pix_div.sv
// Pixel clock divider: free-running div counter, pixel strobe and shift enable.
module video_pix_div
  import efgj03l_video_pkg::*;
#(
  parameter int unsigned PIX_DIV = DEFAULT_PIX_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic active,
  output logic pix_strobe,
  output logic shift_en
);

  localparam int unsigned   DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div;

  // Runs even when the shifter is empty so the strobe cadence never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      pix_strobe <= 1'b0;
    end else begin
      pix_strobe <= (div == '0);
      if (clr || div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  assign shift_en = active && (div == DIV_LAST);

endmodule

// File: rtl/video_pixel_shifter.sv
// Double-buffered form/colour byte serialiser with border insertion and sync alignment.
module video_pixel_shifter
  import efgj03l_video_pkg::*;
#(
  parameter int unsigned PIX_DIV   = DEFAULT_PIX_DIV,
  parameter int unsigned BYTE_BITS = DEFAULT_BYTE_BITS
) (
  input  logic                 PIN_H16,
  input  logic                 RESET,
  input  logic                 FORM_LD,
  input  logic [BYTE_BITS-1:0] FORM_D,
  input  logic                 COLOR_LD,
  input  logic [7:0]           COLOR_D,
  input  logic                 BYTE_START,
  input  logic                 BLANK_IN,
  input  logic                 HSYNC_IN,
  input  logic                 VSYNC_IN,
  input  pal_idx_t             BORDER_COLOR,
  output pal_idx_t             PIX_COLOR,
  output logic                 PIX_STROBE,
  output logic                 BLANK_OUT,
  output logic                 HSYNC_OUT,
  output logic                 VSYNC_OUT,
  output logic                 UNDERRUN
);

  localparam int unsigned   CW        = $clog2(BYTE_BITS + 1);
  localparam logic [CW-1:0] BITS_FULL = CW'(BYTE_BITS);

  logic [BYTE_BITS-1:0] form_h;
  logic [7:0]           color_h;
  logic                 f_v;
  logic                 c_v;
  logic [BYTE_BITS-1:0] shift;
  logic [7:0]           attr;
  logic [CW-1:0]        bitcnt;
  logic                 active;
  logic                 shift_en;

  assign active = (bitcnt != '0);

  video_pix_div #(
    .PIX_DIV(PIX_DIV)
  ) u_pix_div (
    .clk       (PIN_H16),
    .rst       (RESET),
    .clr       (BYTE_START),
    .active    (active),
    .pix_strobe(PIX_STROBE),
    .shift_en  (shift_en)
  );

  always_ff @(posedge PIN_H16) begin
    if (RESET) begin
      form_h    <= '0;
      color_h   <= '0;
      f_v       <= 1'b0;
      c_v       <= 1'b0;
      shift     <= '0;
      attr      <= '0;
      bitcnt    <= '0;
      PIX_COLOR <= '0;
      BLANK_OUT <= 1'b1;
      HSYNC_OUT <= 1'b0;
      VSYNC_OUT <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      // A load coinciding with BYTE_START refills holding and wins over the clear.
      if (FORM_LD) begin
        form_h <= FORM_D;
        f_v    <= 1'b1;
      end else if (BYTE_START) begin
        f_v <= 1'b0;
      end

      if (COLOR_LD) begin
        color_h <= COLOR_D;
        c_v     <= 1'b1;
      end else if (BYTE_START) begin
        c_v <= 1'b0;
      end

      UNDERRUN <= BYTE_START && !(f_v && c_v);

      if (BYTE_START) begin
        shift  <= form_h;
        attr   <= color_h;
        bitcnt <= BITS_FULL;
      end else if (shift_en) begin
        shift  <= shift << 1;
        bitcnt <= bitcnt - CW'(1);
      end

      PIX_COLOR <= (BLANK_IN || !active) ? BORDER_COLOR
                                         : pix_select(attr, shift[BYTE_BITS-1]);
      BLANK_OUT <= BLANK_IN;
      HSYNC_OUT <= HSYNC_IN;
      VSYNC_OUT <= VSYNC_IN;
    end
  end

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Self-checking bench for video_pixel_shifter: timeline-based reference model plus directed literals.
module tb_video_pixel_shifter;

  localparam int PD = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       form_ld = 1'b0, color_ld = 1'b0, byte_start = 1'b0;
  logic       blank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [7:0] form_d = '0, color_d = '0;
  logic [3:0] border = '0;

  logic [3:0] pix_color;
  logic       pix_strobe, blank_out, hsync_out, vsync_out, underrun;

  video_pixel_shifter #(
    .PIX_DIV  (PD),
    .BYTE_BITS(8)
  ) dut (
    .PIN_H16     (clk),
    .RESET       (rst),
    .FORM_LD     (form_ld),
    .FORM_D      (form_d),
    .COLOR_LD    (color_ld),
    .COLOR_D     (color_d),
    .BYTE_START  (byte_start),
    .BLANK_IN    (blank_in),
    .HSYNC_IN    (hsync_in),
    .VSYNC_IN    (vsync_in),
    .BORDER_COLOR(border),
    .PIX_COLOR   (pix_color),
    .PIX_STROBE  (pix_strobe),
    .BLANK_OUT   (blank_out),
    .HSYNC_OUT   (hsync_out),
    .VSYNC_OUT   (vsync_out),
    .UNDERRUN    (underrun)
  );

  int checks = 0;
  int errors = 0;

  // Model state: edge index, when the current byte started, when the divider last restarted.
  int         e = 0;
  int         last_start = 0;
  int         last_clr = 0;
  bit         has_start = 0;
  bit         fl = 0, cl = 0;
  logic [7:0] fh = '0, ch = '0, cur_form = '0, cur_attr = '0;
  logic [3:0] x_color;
  logic       x_strobe, x_blank, x_hs, x_vs, x_und;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Expected outputs after this edge, derived from elapsed time since the byte start.
  task automatic model_edge();
    int k, idx;
    e++;
    if (rst) begin
      x_color = 4'h0; x_strobe = 0; x_blank = 1; x_hs = 0; x_vs = 0; x_und = 0;
      fh = '0; ch = '0; fl = 0; cl = 0; has_start = 0; last_clr = e;
    end else begin
      x_blank = blank_in; x_hs = hsync_in; x_vs = vsync_in;
      x_color = border;
      if (!blank_in && has_start) begin
        k   = e - last_start;
        idx = (k - 1) / PD;
        if (idx < 8) x_color = cur_form[7-idx] ? cur_attr[7:4] : cur_attr[3:0];
      end
      x_strobe = (((e - last_clr - 1) % PD) == 0);
      x_und    = byte_start && !(fl && cl);
      if (byte_start) begin
        cur_form = fh; cur_attr = ch;
        last_start = e; last_clr = e; has_start = 1;
        fl = 0; cl = 0;
      end
      if (form_ld)  begin fh = form_d;  fl = 1; end
      if (color_ld) begin ch = color_d; cl = 1; end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("pix_color",  pix_color,  x_color);
    chk("pix_strobe", pix_strobe, x_strobe);
    chk("blank_out",  blank_out,  x_blank);
    chk("hsync_out",  hsync_out,  x_hs);
    chk("vsync_out",  vsync_out,  x_vs);
    chk("underrun",   underrun,   x_und);
    form_ld = 0; color_ld = 0; byte_start = 0;
  endtask

  task automatic cap16(input string name, input logic [63:0] exp);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk(name, pix_color, exp[63-4*i -: 4]);
    end
  endtask

  initial begin
    // Reset held three clocks
    rst = 1; border = 4'hC;
    repeat (3) cyc();
    chk("rst_color",  pix_color,  4'h0);
    chk("rst_blank",  blank_out,  1'b1);
    chk("rst_under",  underrun,   1'b0);
    chk("rst_strobe", pix_strobe, 1'b0);

    // Byte 0xA5 with attr 0x1E
    rst = 0;
    form_ld = 1; form_d = 8'hA5; color_ld = 1; color_d = 8'h1E;
    cyc();
    chk("strobe_first", pix_strobe, 1'b1);
    byte_start = 1;
    cyc();
    chk("strobe_second", pix_strobe, 1'b0);
    chk("under_ok", underrun, 1'b0);
    cap16("seq_a5", 64'h11EE11EEEE11EE11);

    // Underrun: only the form byte refreshed
    form_ld = 1; form_d = 8'h0F;
    cyc();
    byte_start = 1;
    cyc();
    chk("under_pulse", underrun, 1'b1);
    cap16("seq_0f_stale", 64'hEEEEEEEE11111111);
    chk("under_gone", underrun, 1'b0);

    // Load coinciding with BYTE_START: old holding used, new byte stays valid
    form_ld = 1; form_d = 8'h00; color_ld = 1; color_d = 8'h5A;
    cyc();
    byte_start = 1; form_ld = 1; form_d = 8'hFF; color_ld = 1; color_d = 8'h5A;
    cyc();
    chk("coinc_under", underrun, 1'b0);
    cap16("seq_bg", 64'hAAAAAAAAAAAAAAAA);
    border = 4'h3;
    byte_start = 1;
    cyc();
    chk("follow_under", underrun, 1'b0);
    cap16("seq_fg", 64'h5555555555555555);

    // Shifter empty -> border
    cyc();
    chk("empty_border", pix_color, 4'h3);
    cyc();
    chk("empty_border2", pix_color, 4'h3);

    // Blank mid-byte, then reset mid-byte
    form_ld = 1; form_d = 8'hAA; color_ld = 1; color_d = 8'h70;
    cyc();
    byte_start = 1;
    cyc();
    repeat (4) cyc();
    blank_in = 1;
    cyc();
    chk("blank_color", pix_color, 4'h3);
    chk("blank_out",   blank_out, 1'b1);
    blank_in = 0;
    cyc();
    cyc();
    rst = 1;
    cyc();
    chk("midrst_color", pix_color, 4'h0);
    rst = 0;

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 399) == 0);
      form_ld    = ($urandom_range(0, 3) == 0);
      form_d     = 8'($urandom);
      color_ld   = ($urandom_range(0, 3) == 0);
      color_d    = 8'($urandom);
      byte_start = ($urandom_range(0, 13) == 0);
      blank_in   = ($urandom_range(0, 9) == 0);
      hsync_in   = ($urandom_range(0, 5) == 0);
      vsync_in   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 31) == 0) border = 4'($urandom);
      cyc();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
